// File: rtl/sat_acc_pkg.sv
// -----------------------------------------------------------------------------
// sat_acc_pkg
// Shared types and helpers for the saturating block accumulator.
//   state_t  : block controller state (ACC collects samples, HOLD presents result)
//   sat_max  : most positive two's-complement value for a given width
//   sat_min  : most negative two's-complement value for a given width
//   add_ovf  : signed-add overflow predicate from operand and result sign bits
// The saturation constants are returned MAX_W bits wide; callers keep the low
// 'width' bits, which makes the helpers usable for any width up to MAX_W.
// -----------------------------------------------------------------------------
package sat_acc_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 32'd1)) - 64'd1;
  endfunction

  // Low 'width' bits of the inverted maximum are 1000...0, the most negative value.
  function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  // Overflow only when both operands share a sign and the result sign differs.
  function automatic logic add_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Combinational two's-complement adder that clamps instead of wrapping.
//   a, b : signed operands (WIDTH)
//   sum  : a + b, clamped to [SAT_MIN, SAT_MAX] (WIDTH)
//   ovf  : 1 when the clamp was applied
// -----------------------------------------------------------------------------
module sat_add
  import sat_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [MAX_W-1:0] SAT_MAX_W = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] SAT_MIN_W = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

  logic [WIDTH-1:0] raw_s;

  assign raw_s = a + b;

  // Detect overflow and clamp toward the sign of the operands.
  always_comb begin
    ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], raw_s[WIDTH-1]);
    if (ovf) begin
      if (a[WIDTH-1]) begin
        sum = SAT_MIN;
      end else begin
        sum = SAT_MAX;
      end
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/sat_block_accumulator.sv
// -----------------------------------------------------------------------------
// sat_block_accumulator
// Sums COUNT signed samples per block with per-sample saturation and presents
// one result per block with a sticky overflow flag and an overflow count.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid     : sample on in_data is valid
//   in_ready     : block accepts a sample this cycle (ACC state, not in reset)
//   in_data      : signed sample (WIDTH)
//   out_valid    : block result is presented (HOLD state)
//   out_ready    : sink takes the result
//   out_sum      : saturated block sum (WIDTH)
//   out_ovf      : at least one saturation event in the block
//   out_ovf_cnt  : number of saturation events in the block (CW)
// The HOLD->ACC transition costs one cycle, so a block takes COUNT+1 cycles
// minimum.
// -----------------------------------------------------------------------------
module sat_block_accumulator
  import sat_acc_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned COUNT = 4,
  localparam int unsigned CW    = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CW-1:0]    out_ovf_cnt
);

  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CW-1:0]    out_ovf_cnt_q, out_ovf_cnt_d;

  logic [WIDTH-1:0] add_sum_s;
  logic             add_ovf_s;
  logic             in_ready_s;
  logic             accept_s;

  sat_add #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum_s),
    .ovf (add_ovf_s)
  );

  // in_ready depends only on state and rst, never on in_valid.
  assign in_ready_s  = (state_q == ACC) && !rst;
  assign accept_s    = in_valid && in_ready_s;

  assign in_ready    = in_ready_s;
  assign out_valid   = (state_q == HOLD);
  assign out_sum     = out_sum_q;
  assign out_ovf     = out_ovf_q;
  assign out_ovf_cnt = out_ovf_cnt_q;

  // Next-state logic for the accumulator and the result registers.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_cnt_d     = ovf_cnt_q;
    out_sum_d     = out_sum_q;
    out_ovf_d     = out_ovf_q;
    out_ovf_cnt_d = out_ovf_cnt_q;
    case (state_q)
      ACC: begin
        if (accept_s) begin
          acc_d     = add_sum_s;
          cnt_d     = cnt_q + CW'(1);
          ovf_cnt_d = ovf_cnt_q + CW'(add_ovf_s);
          // The last sample of the block publishes the result on the same edge.
          if (cnt_q == LAST_IDX) begin
            out_sum_d     = add_sum_s;
            out_ovf_cnt_d = ovf_cnt_d;
            out_ovf_d     = (ovf_cnt_d != '0);
            state_d       = HOLD;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = ACC;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_cnt_d = '0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d   = ACC;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACC;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_cnt_q     <= '0;
      out_sum_q     <= '0;
      out_ovf_q     <= 1'b0;
      out_ovf_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_cnt_q     <= ovf_cnt_d;
      out_sum_q     <= out_sum_d;
      out_ovf_q     <= out_ovf_d;
      out_ovf_cnt_q <= out_ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_sat_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sat_block_accumulator
// Self-checking bench for sat_block_accumulator (WIDTH=8, COUNT=4). Expected
// results come from directed constants or from an integer reference model that
// sums with clamping to [-128, 127].
// -----------------------------------------------------------------------------
module tb_sat_block_accumulator;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int CW    = $clog2(COUNT + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [CW-1:0]    out_ovf_cnt;

  int n_cmp;
  int n_err;

  sat_block_accumulator #(
    .WIDTH (WIDTH),
    .COUNT (COUNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_ovf     (out_ovf),
    .out_ovf_cnt (out_ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: running sum clamped to the signed 8-bit range after every sample.
  function automatic void ref_block(input int s[4], output int sum, output int novf);
    int t;
    sum  = 0;
    novf = 0;
    for (int i = 0; i < COUNT; i++) begin
      t = sum + s[i];
      if (t > 127) begin
        t = 127;
        novf++;
      end else if (t < -128) begin
        t = -128;
        novf++;
      end
      sum = t;
    end
  endfunction

  // Feeds one block, optionally with random idle gaps; returns #1 after the last accept.
  task automatic drive_block(input int s[4], input int gap_max);
    int gaps;
    int w;
    for (int i = 0; i < COUNT; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) begin
        n_cmp++; n_err++;
        $display("FAIL drive_wait: in_ready=%0b after 20 cycles, required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = 8'(s[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd55; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b, required 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    n_cmp++; if (out_sum !== 8'd0 || out_ovf !== 1'b0 || out_ovf_cnt !== 3'd0) begin
      n_err++; $display("FAIL reset_outputs: got sum=%0h ovf=%0b cnt=%0d, required 0/0/0", out_sum, out_ovf, out_ovf_cnt);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b, required 1", in_ready); end
  endtask

  task automatic test_no_overflow();
    int s[4];
    s = '{10, 20, 30, 40};
    drive_block(s, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL noovf_latency: out_valid=%0b, required 1", out_valid); end
    n_cmp++; if (out_sum !== 8'h64 || out_ovf !== 1'b0 || out_ovf_cnt !== 3'd0) begin
      n_err++; $display("FAIL noovf_result: got sum=%0h ovf=%0b cnt=%0d, required 64/0/0", out_sum, out_ovf, out_ovf_cnt);
    end
    release_result();
  endtask

  task automatic test_saturation();
    int s[4];
    logic [7:0] exp_sum [2];
    logic [2:0] exp_cnt [2];
    exp_sum = '{8'h57, 8'hB2};
    exp_cnt = '{3'd1, 3'd2};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) s = '{100, 100, -50, 10};
      else        s = '{-100, -100, -100, 50};
      drive_block(s, 0);
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== exp_sum[k] || out_ovf !== 1'b1 || out_ovf_cnt !== exp_cnt[k]) begin
        n_err++; $display("FAIL sat_%0d: got valid=%0b sum=%0h ovf=%0b cnt=%0d, required 1/%0h/1/%0d",
                          k, out_valid, out_sum, out_ovf, out_ovf_cnt, exp_sum[k], exp_cnt[k]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int s[4];
    s = '{10, 20, 30, 40};
    drive_block(s, 3);
    for (int c = 0; c < 3; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_data  = 8'h7F;
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_handshake: got in_ready=%0b out_valid=%0b, required 0/1", in_ready, out_valid);
      end
      n_cmp++; if (out_sum !== 8'h64 || out_ovf !== 1'b0 || out_ovf_cnt !== 3'd0) begin
        n_err++; $display("FAIL hold_stable: got sum=%0h ovf=%0b cnt=%0d, required 64/0/0", out_sum, out_ovf, out_ovf_cnt);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_result();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release: got in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int s[4];
    in_valid = 1'b1; in_data = 8'd5; @(posedge clk); #1;
    in_data = 8'd6; @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %0b, required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b, required 0", out_valid); end
    s = '{1, 1, 1, 1};
    drive_block(s, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 8'd4 || out_ovf_cnt !== 3'd0 || out_ovf !== 1'b0) begin
      n_err++; $display("FAIL rstmid_block: got valid=%0b sum=%0h cnt=%0d ovf=%0b, required 1/4/0/0",
                        out_valid, out_sum, out_ovf_cnt, out_ovf);
    end
    // Reset while the result is held: it must vanish without a handshake.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
      n_err++; $display("FAIL rsthold_drop: got valid=%0b sum=%0h, required 0/0", out_valid, out_sum);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL rsthold_idle: got valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int q[12];
    int blk[4];
    int idx;
    int pulses;
    int esum;
    int enovf;
    logic exp_v;
    for (int i = 0; i < 12; i++) q[i] = int'($urandom_range(0, 255)) - 128;
    idx = 0; pulses = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 17; cyc++) begin
      exp_v = (cyc < 15) && (cyc % 5 == 4);
      n_cmp++; if (out_valid !== exp_v) begin
        n_err++; $display("FAIL b2b_valid cyc %0d: got %0b, required %0b", cyc, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && pulses < 3) begin
        for (int j = 0; j < 4; j++) blk[j] = q[pulses * 4 + j];
        ref_block(blk, esum, enovf);
        n_cmp++; if (out_sum !== 8'(esum) || out_ovf_cnt !== 3'(enovf) || out_ovf !== (enovf != 0)) begin
          n_err++; $display("FAIL b2b_result blk %0d: got sum=%0h cnt=%0d ovf=%0b, required %0h/%0d/%0b",
                            pulses, out_sum, out_ovf_cnt, out_ovf, 8'(esum), enovf, enovf != 0);
        end
        pulses++;
      end
      in_valid = (idx < 12);
      in_data  = (idx < 12 && in_ready) ? 8'(q[idx]) : 8'h80;
      if (in_ready && idx < 12) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses: got %0d, required 3", pulses); end
  endtask

  task automatic test_random();
    int s[4];
    int esum;
    int enovf;
    int hold;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (b % 2 == 0) s[i] = int'($urandom_range(0, 255)) - 128;
        else            s[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(60, 127)) : -int'($urandom_range(60, 128));
      end
      ref_block(s, esum, enovf);
      drive_block(s, 2);
      hold = int'($urandom_range(0, 3));
      for (int c = 0; c <= hold; c++) begin
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== 8'(esum) || out_ovf_cnt !== 3'(enovf) || out_ovf !== (enovf != 0)) begin
          n_err++; $display("FAIL rand blk %0d: got valid=%0b sum=%0h cnt=%0d ovf=%0b, required 1/%0h/%0d/%0b",
                            b, out_valid, out_sum, out_ovf_cnt, out_ovf, 8'(esum), enovf, enovf != 0);
        end
        if (c < hold) begin
          @(posedge clk); #1;
        end
      end
      release_result();
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_no_overflow();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
